doorlock_ctrl: RTL and testbench



---
 rtl/doorlock_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_doorlock_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doorlock_ctrl.sv
// Doorlock decision FSM: accumulates one-hot digit pulses, checks the code on star,
// drives open/lockout levels and led/err pulses. `DOORLOCK_PWCHG_EN adds passcode change.
module doorlock_ctrl #(
  parameter int          PW_LEN   = 4,
  parameter logic [31:0] DEF_PW   = 32'h0000_1234,
  parameter int          MAX_FAIL = 3,
  parameter logic [27:0] T_OPEN   = 28'd150_000_000,
  parameter logic [27:0] T_LOCK   = 28'd250_000_000,
  parameter logic [27:0] T_TMO    = 28'd250_000_000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [9:0] bt_i,
  input  logic       btstar_i,
  output logic       open_o,
  output logic       led_o,
  output logic       err_o,
  output logic       lock_o,
  output logic [3:0] dig_cnt_o,
  output logic       pwset_o
);
  localparam int BW = 4 * PW_LEN;

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_OPEN, S_LOCK
`ifdef DOORLOCK_PWCHG_EN
    , S_PWSET
`endif
  } state_t;

  state_t      state, state_nx;
  logic [BW-1:0] code_q, pw_q;
  logic [3:0]  cnt_q, fail_q, fail_inc;
  logic [27:0] tmr_q;
  logic [3:0]  dig;
  logic        dig_vld, tmo, match;
  logic        ev_dig, ev_succ, ev_fail, ev_clr, ev_pwok, ev_pwbad, ev_lkend;
  logic        open_nx, led_nx, err_nx, lock_nx, pwset_nx;

  always_comb begin
    dig = '0;
    for (int k = 0; k < 10; k++)
      if (bt_i[k]) dig = 4'(k);
  end

  // star has priority: a digit arriving with star is dropped
  assign dig_vld  = $onehot(bt_i) && !btstar_i;
  assign tmo      = (tmr_q <= 28'd1);
  assign match    = (cnt_q == 4'(PW_LEN)) && (code_q == pw_q);
  assign fail_inc = fail_q + 4'd1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ev_dig   = 1'b0;
    ev_succ  = 1'b0;
    ev_fail  = 1'b0;
    ev_clr   = 1'b0;
    ev_pwok  = 1'b0;
    ev_pwbad = 1'b0;
    ev_lkend = 1'b0;
    unique case (state)
      S_IDLE, S_ENTRY: begin
        if (btstar_i && state == S_ENTRY) begin
          if (match) begin
            ev_succ  = 1'b1;
            state_nx = S_OPEN;
          end else begin
            ev_fail  = 1'b1;
            state_nx = (fail_inc == 4'(MAX_FAIL)) ? S_LOCK : S_IDLE;
          end
        end else if (dig_vld) begin
          ev_dig   = 1'b1;
          state_nx = S_ENTRY;
        end else if (state == S_ENTRY && tmo) begin
          ev_clr   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_OPEN: begin
`ifdef DOORLOCK_PWCHG_EN
        if (btstar_i)  state_nx = S_PWSET;
        else if (tmo)  state_nx = S_IDLE;
`else
        if (tmo) state_nx = S_IDLE;
`endif
      end
      S_LOCK: begin
        if (tmo) begin
          ev_lkend = 1'b1;
          state_nx = S_IDLE;
        end
      end
`ifdef DOORLOCK_PWCHG_EN
      S_PWSET: begin
        if (btstar_i) begin
          ev_pwok  = (cnt_q == 4'(PW_LEN));
          ev_pwbad = (cnt_q != 4'(PW_LEN));
          state_nx = S_IDLE;
        end else if (dig_vld) begin
          ev_dig = 1'b1;
        end else if (tmo) begin
          ev_pwbad = 1'b1;
          state_nx = S_IDLE;
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    open_nx  = (state_nx == S_OPEN);
    lock_nx  = (state_nx == S_LOCK);
    led_nx   = ev_succ | ev_pwok;
    err_nx   = ev_fail | ev_pwbad;
`ifdef DOORLOCK_PWCHG_EN
    pwset_nx = (state_nx == S_PWSET);
`else
    pwset_nx = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      {open_o, led_o, err_o, lock_o, pwset_o} <= '0;
    end else begin
      open_o  <= open_nx;
      led_o   <= led_nx;
      err_o   <= err_nx;
      lock_o  <= lock_nx;
      pwset_o <= pwset_nx;
    end
  end

  // one shared timer, reloaded on each state entry and on every accepted digit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmr_q <= '0;
    end else if (state_nx != state || ev_dig) begin
      unique case (state_nx)
        S_OPEN:  tmr_q <= T_OPEN;
        S_LOCK:  tmr_q <= T_LOCK;
        S_IDLE:  tmr_q <= '0;
        default: tmr_q <= T_TMO;
      endcase
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - 28'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      code_q <= '0;
      cnt_q  <= '0;
      fail_q <= '0;
    end else begin
      if (ev_dig) begin
        code_q <= (code_q << 4) | BW'(dig);
        if (cnt_q != 4'(PW_LEN)) cnt_q <= cnt_q + 4'd1;
      end else if (ev_succ | ev_fail | ev_clr | ev_pwok | ev_pwbad) begin
        code_q <= '0;
        cnt_q  <= '0;
      end
      if (ev_succ | ev_lkend) fail_q <= '0;
      else if (ev_fail)       fail_q <= fail_inc;
    end
  end

`ifdef DOORLOCK_PWCHG_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       pw_q <= DEF_PW[BW-1:0];
    else if (ev_pwok) pw_q <= code_q;
  end
`else
  assign pw_q = DEF_PW[BW-1:0];
`endif

  assign dig_cnt_o = cnt_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Bench for doorlock_ctrl: directed scenarios plus random traffic against an
// event-level model (digit list, deadline cycle numbers, passcode array).
module tb_doorlock_ctrl;
  localparam int PW = 4, MAX_FAIL = 3, T_OPEN = 8, T_LOCK = 12, T_TMO = 10;
`ifdef DOORLOCK_PWCHG_EN
  localparam bit PWCHG = 1'b1;
`else
  localparam bit PWCHG = 1'b0;
`endif
  localparam int M_IDLE = 0, M_OPEN = 1, M_LOCK = 2, M_PWSET = 3;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [9:0] bt_i;
  logic       btstar_i;
  logic       open_o, led_o, err_o, lock_o, pwset_o;
  logic [3:0] dig_cnt_o;
  logic [8:0] dut_vec;

  int vecs = 0, miss = 0;

  doorlock_ctrl #(.PW_LEN(PW), .DEF_PW(32'h0000_1234), .MAX_FAIL(MAX_FAIL),
                  .T_OPEN(28'd8), .T_LOCK(28'd12), .T_TMO(28'd10)) dut (
    .clk(clk), .n_rst(n_rst), .bt_i(bt_i), .btstar_i(btstar_i),
    .open_o(open_o), .led_o(led_o), .err_o(err_o), .lock_o(lock_o),
    .dig_cnt_o(dig_cnt_o), .pwset_o(pwset_o));

  always #5 clk = ~clk;
  assign dut_vec = {open_o, led_o, err_o, lock_o, pwset_o, dig_cnt_o};

  // ---------------- reference model ----------------
  int   m_mode, m_fails, m_dl, m_n;
  int   m_digs[$];
  int   m_pw[PW];
  logic e_led, e_err;

  function automatic void model_reset();
    m_mode = M_IDLE; m_fails = 0; m_dl = 0; m_n = 0;
    m_digs.delete();
    m_pw[0] = 1; m_pw[1] = 2; m_pw[2] = 3; m_pw[3] = 4;
    e_led = 1'b0; e_err = 1'b0;
  endfunction

  function automatic void add_digit(int d);
    m_digs.push_back(d);
    if (m_digs.size() > PW) void'(m_digs.pop_front());
    m_dl = m_n + T_TMO;
  endfunction

  function automatic void model_step(logic [9:0] b, logic s);
    int d; bit dv, ok;
    m_n++; e_led = 1'b0; e_err = 1'b0;
    dv = ($countones(b) == 1) && !s;
    d = 0;
    for (int k = 0; k < 10; k++) if (b[k]) d = k;
    case (m_mode)
      M_IDLE: begin
        if (s && m_digs.size() > 0) begin
          ok = (m_digs.size() == PW);
          if (ok) for (int i = 0; i < PW; i++) if (m_digs[i] != m_pw[i]) ok = 0;
          if (ok) begin
            m_mode = M_OPEN; m_dl = m_n + T_OPEN; m_fails = 0; e_led = 1'b1;
          end else begin
            e_err = 1'b1; m_fails++;
            if (m_fails == MAX_FAIL) begin m_mode = M_LOCK; m_dl = m_n + T_LOCK; end
          end
          m_digs.delete();
        end else if (dv) add_digit(d);
        else if (m_digs.size() > 0 && m_n == m_dl) m_digs.delete();
      end
      M_OPEN: begin
        if (PWCHG && s) begin m_mode = M_PWSET; m_dl = m_n + T_TMO; end
        else if (m_n == m_dl) m_mode = M_IDLE;
      end
      M_LOCK: if (m_n == m_dl) begin m_mode = M_IDLE; m_fails = 0; end
      default: begin
        if (s) begin
          if (m_digs.size() == PW) begin
            for (int i = 0; i < PW; i++) m_pw[i] = m_digs[i];
            e_led = 1'b1;
          end else e_err = 1'b1;
          m_digs.delete(); m_mode = M_IDLE;
        end else if (dv) add_digit(d);
        else if (m_n == m_dl) begin e_err = 1'b1; m_digs.delete(); m_mode = M_IDLE; end
      end
    endcase
  endfunction

  function automatic logic [8:0] exp_vec();
    return {m_mode == M_OPEN, e_led, e_err, m_mode == M_LOCK, m_mode == M_PWSET,
            4'(m_digs.size())};
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick(input logic [9:0] b, input logic s);
    bt_i = b; btstar_i = s;
    @(posedge clk);
    model_step(b, s);
    @(negedge clk);
    bt_i = '0; btstar_i = 1'b0;
  endtask

  // code 0..9 digit, 10 star, anything else idle
  task automatic apply(input int c);
    logic [9:0] one;
    one = 10'b1;
    if (c < 10)       tick(one << c, 1'b0);
    else if (c == 10) tick('0, 1'b1);
    else              tick('0, 1'b0);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; bt_i = '0; btstar_i = 1'b0;
    model_reset();
    #12;
    vecs++;
    if (dut_vec !== 9'b0) begin miss++; $display("FAIL reset: got %b want %b", dut_vec, 9'b0); end
    @(negedge clk); n_rst = 1'b1;
  endtask

  task automatic test_open();
    int hi;
    hi = 0;
    for (int i = 0; i < 17; i++) begin
      apply(i < 4 ? i + 1 : (i == 4 ? 10 : 11));
      vecs++;
      if (dut_vec !== exp_vec()) begin miss++; $display("FAIL open_seq[%0d]: got %b want %b", i, dut_vec, exp_vec()); end
      if (i == 4) begin
        vecs++;
        if ({open_o, led_o} !== 2'b11) begin miss++; $display("FAIL open_led: got %b want 11", {open_o, led_o}); end
      end
      if (i == 5) begin
        vecs++;
        if (led_o !== 1'b0) begin miss++; $display("FAIL led_one_cycle: got %b want 0", led_o); end
      end
      if (open_o) hi++;
    end
    vecs++;
    if (hi != T_OPEN) begin miss++; $display("FAIL open_len: got %0d want %0d", hi, T_OPEN); end
  endtask

  task automatic test_lockout();
    int lk, anyopen;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 5; i++) begin
        apply(i == 0 ? 1 : i == 1 ? 2 : i == 2 ? 3 : i == 3 ? 5 : 10);
        vecs++;
        if (dut_vec !== exp_vec()) begin miss++; $display("FAIL bad_code[%0d.%0d]: got %b want %b", r, i, dut_vec, exp_vec()); end
      end
    vecs++;
    if ({err_o, lock_o} !== 2'b11) begin miss++; $display("FAIL lock_enter: got %b want 11", {err_o, lock_o}); end
    lk = 1; anyopen = 0;
    for (int j = 0; j < 16; j++) begin
      apply(j < 4 ? j + 1 : (j == 4 ? 10 : 11));
      vecs++;
      if (dut_vec !== exp_vec()) begin miss++; $display("FAIL lock_hold[%0d]: got %b want %b", j, dut_vec, exp_vec()); end
      if (lock_o) lk++;
      if (open_o) anyopen++;
    end
    vecs++;
    if (lk != T_LOCK) begin miss++; $display("FAIL lock_len: got %0d want %0d", lk, T_LOCK); end
    vecs++;
    if (anyopen != 0) begin miss++; $display("FAIL lock_ignores: got %0d opens want 0", anyopen); end
    for (int i = 0; i < 5; i++) apply(i < 4 ? i + 1 : 10);
    vecs++;
    if (open_o !== 1'b1) begin miss++; $display("FAIL open_after_lock: got %b want 1", open_o); end
    for (int i = 0; i < 10; i++) apply(11);
  endtask

  task automatic test_overflow();
    int seq[6];
    seq = '{9, 1, 2, 3, 4, 10};
    for (int i = 0; i < 6; i++) begin
      apply(seq[i]);
      vecs++;
      if (dut_vec !== exp_vec()) begin miss++; $display("FAIL ovf_seq[%0d]: got %b want %b", i, dut_vec, exp_vec()); end
    end
    vecs++;
    if (open_o !== 1'b1) begin miss++; $display("FAIL ovf_open: got %b want 1", open_o); end
    for (int i = 0; i < 10; i++) apply(11);
    for (int i = 0; i < 4; i++) apply(i < 3 ? i + 1 : 10);
    vecs++;
    if ({err_o, open_o, dig_cnt_o} !== 6'b10_0000) begin miss++; $display("FAIL short_code: got %b want 100000", {err_o, open_o, dig_cnt_o}); end
  endtask

  task automatic test_invalid();
    apply(1);
    tick(10'h003, 1'b0);
    vecs++;
    if (dig_cnt_o !== 4'd1) begin miss++; $display("FAIL multi_hot: got %0d want 1", dig_cnt_o); end
    tick('0, 1'b0);
    vecs++;
    if (dig_cnt_o !== 4'd1) begin miss++; $display("FAIL zero_hot: got %0d want 1", dig_cnt_o); end
    apply(2); apply(3);
    tick(10'h010, 1'b1);  // digit 4 with star: digit dropped, 3-digit code fails
    vecs++;
    if ({err_o, open_o, dig_cnt_o} !== 6'b10_0000) begin miss++; $display("FAIL star_wins: got %b want 100000", {err_o, open_o, dig_cnt_o}); end
    vecs++;
    if (dut_vec !== exp_vec()) begin miss++; $display("FAIL invalid_model: got %b want %b", dut_vec, exp_vec()); end
    for (int i = 0; i < 15; i++) apply(i < 4 ? i + 1 : (i == 4 ? 10 : 11));
  endtask

  task automatic test_timeout();
    int errs;
    errs = 0;
    apply(1); apply(2);
    for (int i = 0; i < 10; i++) begin
      apply(11);
      vecs++;
      if (dut_vec !== exp_vec()) begin miss++; $display("FAIL tmo_seq[%0d]: got %b want %b", i, dut_vec, exp_vec()); end
      if (i == 8) begin
        vecs++;
        if (dig_cnt_o !== 4'd2) begin miss++; $display("FAIL tmo_early: got %0d want 2", dig_cnt_o); end
      end
      if (err_o) errs++;
    end
    vecs++;
    if (dig_cnt_o !== 4'd0 || errs != 0) begin miss++; $display("FAIL tmo_clear: got cnt %0d errs %0d want 0 0", dig_cnt_o, errs); end
  endtask

`ifdef DOORLOCK_PWCHG_EN
  task automatic test_pwchg();
    int seq[27];
    seq = '{1,2,3,4,10, 10, 5,6,7,8,10, 5,6,7,8,10, 11,11,11,11,11,11,11,11, 1,2,3};
    for (int i = 0; i < 27; i++) begin
      apply(seq[i]);
      vecs++;
      if (dut_vec !== exp_vec()) begin miss++; $display("FAIL pwchg_seq[%0d]: got %b want %b", i, dut_vec, exp_vec()); end
      if (i == 5) begin
        vecs++;
        if ({pwset_o, open_o} !== 2'b10) begin miss++; $display("FAIL pwset_enter: got %b want 10", {pwset_o, open_o}); end
      end
      if (i == 10) begin
        vecs++;
        if ({led_o, pwset_o} !== 2'b10) begin miss++; $display("FAIL pwset_done: got %b want 10", {led_o, pwset_o}); end
      end
      if (i == 15) begin
        vecs++;
        if (open_o !== 1'b1) begin miss++; $display("FAIL new_pw_open: got %b want 1", open_o); end
      end
    end
    apply(4); apply(10);
    vecs++;
    if ({err_o, open_o} !== 2'b10) begin miss++; $display("FAIL old_pw_rejected: got %b want 10", {err_o, open_o}); end
  endtask
`else
  task automatic test_star_open();
    for (int i = 0; i < 7; i++) begin
      apply(i < 4 ? i + 1 : 10);
      vecs++;
      if (dut_vec !== exp_vec()) begin miss++; $display("FAIL star_open_seq[%0d]: got %b want %b", i, dut_vec, exp_vec()); end
    end
    vecs++;
    if ({open_o, pwset_o} !== 2'b10) begin miss++; $display("FAIL star_in_open: got %b want 10", {open_o, pwset_o}); end
    for (int i = 0; i < 10; i++) apply(11);
  endtask
`endif

  task automatic test_reset_mid_open();
    int code[PW];
    for (int i = 0; i < PW; i++) code[i] = m_pw[i];
    for (int i = 0; i < PW; i++) apply(code[i]);
    apply(10); apply(11); apply(11);
    vecs++;
    if (open_o !== 1'b1) begin miss++; $display("FAIL pre_reset_open: got %b want 1", open_o); end
    #2 n_rst = 1'b0;
    #1;
    vecs++;
    if (dut_vec !== 9'b0) begin miss++; $display("FAIL async_reset: got %b want 0", dut_vec); end
    model_reset();
    @(negedge clk); n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(i < 4 ? i + 1 : 10);
      vecs++;
      if (dut_vec !== exp_vec()) begin miss++; $display("FAIL revert_seq[%0d]: got %b want %b", i, dut_vec, exp_vec()); end
    end
    vecs++;
    if (open_o !== 1'b1) begin miss++; $display("FAIL pw_revert: got %b want 1", open_o); end
    for (int i = 0; i < 10; i++) apply(11);
  endtask

  task automatic test_random();
    int r, code[PW];
    for (int n = 0; n < 600; n++) begin
      if (m_mode == M_IDLE && m_digs.size() == 0 && $urandom_range(0, 5) == 0) begin
        for (int i = 0; i < PW; i++) code[i] = m_pw[i];
        for (int i = 0; i <= PW; i++) begin
          apply(i < PW ? code[i] : 10);
          vecs++;
          if (dut_vec !== exp_vec()) begin miss++; $display("FAIL rnd_code[%0d]: got %b want %b", n, dut_vec, exp_vec()); end
        end
      end else begin
        r = $urandom_range(0, 99);
        if (r < 45)      tick('0, 1'b0);
        else if (r < 75) apply($urandom_range(0, 9));
        else if (r < 85) tick('0, 1'b1);
        else if (r < 92) tick(10'($urandom) | 10'h201, 1'b0);
        else             tick(10'b1 << $urandom_range(0, 9), 1'b1);
        vecs++;
        if (dut_vec !== exp_vec()) begin miss++; $display("FAIL rnd[%0d]: got %b want %b", n, dut_vec, exp_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_lockout();
    test_overflow();
    test_invalid();
    test_timeout();
`ifdef DOORLOCK_PWCHG_EN
    test_pwchg();
`else
    test_star_open();
`endif
    test_reset_mid_open();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
